// File: rtl/pipeline_stall_regs_pkg.sv
// Shared pipeline constants and register payload layouts for the front-end
// stall/flush register block.
package pipeline_stall_regs_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;

  localparam int unsigned CTRL_MEMREAD  = 1;
  localparam int unsigned CTRL_REGWRITE = 0;

  localparam logic [XLEN-1:0] PIPE_NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PIPE_RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rd;
  } ex_regs_t;

endpackage

// File: rtl/pipeline_stall_regs_en_clr.sv
// Width-parameterised pipeline register: synchronous clear wins over enable,
// clear loads CLR_VAL.
module pipe_reg_en_clr #(
  parameter int unsigned   W       = 32,
  parameter logic [W-1:0]  CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      q_q <= CLR_VAL;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipeline_stall_regs.sv
// PC, IF/ID and ID/EX registers with load-use hold/bubble, taken-branch
// redirect/flush and a saturating stall-cycle counter.
module pipeline_stall_regs
  import pipeline_stall_regs_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = PIPE_RESET_PC,
  parameter int unsigned CTRL_W    = 8,
  parameter logic [31:0] NOP_INSTR = PIPE_NOP_INSTR,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_gate,
  input  logic              control_signals_select,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic [31:0]       imem_instr,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  output logic [31:0]       pc,
  output logic [31:0]       if_id_pc,
  output logic [31:0]       if_id_instr,
  output logic              if_id_valid,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic [4:0]        id_ex_rs1,
  output logic [4:0]        id_ex_rs2,
  output logic [4:0]        id_ex_rd,
  output logic              id_ex_memRead,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int unsigned IFID_W = $bits(if_id_t);
  localparam int unsigned REGS_W = $bits(ex_regs_t);
  localparam int unsigned IDEX_W = CTRL_W + REGS_W;

  localparam logic [IFID_W-1:0] IFID_CLR = IFID_W'({32'h0, NOP_INSTR, 1'b0});

  logic [31:0] pc_d;
  logic [31:0] pc_q;
  logic        pc_en;

  if_id_t if_id_d;
  if_id_t if_id_q;
  logic   if_id_clr;

  logic              bubble;
  logic [CTRL_W-1:0] ctrl_d;
  ex_regs_t          regs_d;
  logic [IDEX_W-1:0] id_ex_d;
  logic [IDEX_W-1:0] id_ex_q;

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // A taken branch redirects even while the fetch side is held.
  always_comb begin
    pc_en = branch_taken | clk_gate;
    pc_d  = pc_q + 32'd4;
    if (branch_taken) begin
      pc_d = branch_target;
    end
  end

  pipe_reg_en_clr #(
    .W       (32),
    .CLR_VAL (RESET_PC)
  ) u_pc (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (pc_en),
    .d_i   (pc_d),
    .q_o   (pc_q)
  );

  // Flush shares the reset image: NOP with valid cleared.
  always_comb begin
    if_id_clr     = rst | branch_taken;
    if_id_d.pc    = pc_q;
    if_id_d.instr = imem_instr;
    if_id_d.valid = 1'b1;
  end

  pipe_reg_en_clr #(
    .W       (IFID_W),
    .CLR_VAL (IFID_CLR)
  ) u_if_id (
    .clk   (clk),
    .clr_i (if_id_clr),
    .en_i  (clk_gate),
    .d_i   (if_id_d),
    .q_o   (if_id_q)
  );

  // Source fields always load; only ctrl and rd are squashed for a bubble.
  always_comb begin
    bubble     = branch_taken | ~control_signals_select;
    ctrl_d     = id_ctrl & {CTRL_W{if_id_q.valid}};
    regs_d.rs1 = id_rs1;
    regs_d.rs2 = id_rs2;
    regs_d.rd  = id_rd;
    if (bubble) begin
      ctrl_d    = '0;
      regs_d.rd = 5'd0;
    end
    id_ex_d = {ctrl_d, regs_d};
  end

  pipe_reg_en_clr #(
    .W       (IDEX_W),
    .CLR_VAL (IDEX_W'(0))
  ) u_id_ex (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (1'b1),
    .d_i   (id_ex_d),
    .q_o   (id_ex_q)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (!branch_taken && !clk_gate && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pc            = pc_q;
  assign if_id_pc      = if_id_q.pc;
  assign if_id_instr   = if_id_q.instr;
  assign if_id_valid   = if_id_q.valid;
  assign {id_ex_ctrl, id_ex_rs1, id_ex_rs2, id_ex_rd} = id_ex_q;
  assign id_ex_memRead = id_ex_q[REGS_W + CTRL_MEMREAD];
  assign stall_count   = cnt_q;

endmodule

// File: tb/tb_pipeline_stall_regs.sv
// Scoreboard bench for pipeline_stall_regs: directed steps push hand-computed
// post-edge expectations; a monitor pops and compares after every edge.
module tb_pipeline_stall_regs;

  localparam int unsigned CTRL_W = 8;
  localparam int unsigned CNT_W  = 16;

  localparam logic [4:0] M_PC  = 5'b00001;
  localparam logic [4:0] M_IF  = 5'b00010;
  localparam logic [4:0] M_EXC = 5'b00100;
  localparam logic [4:0] M_RS  = 5'b01000;
  localparam logic [4:0] M_CNT = 5'b10000;
  localparam logic [4:0] M_ALL = 5'b11111;

  typedef struct packed {
    logic [4:0]  mask;
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] instr;
    logic        valid;
    logic [7:0]  ctrl;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [15:0] cnt;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              clk_gate;
  logic              control_signals_select;
  logic              branch_taken;
  logic [31:0]       branch_target;
  logic [31:0]       imem_instr;
  logic [CTRL_W-1:0] id_ctrl;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic [31:0]       pc;
  logic [31:0]       if_id_pc;
  logic [31:0]       if_id_instr;
  logic              if_id_valid;
  logic [CTRL_W-1:0] id_ex_ctrl;
  logic [4:0]        id_ex_rs1;
  logic [4:0]        id_ex_rs2;
  logic [4:0]        id_ex_rd;
  logic              id_ex_memRead;
  logic [CNT_W-1:0]  stall_count;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  pipeline_stall_regs #(
    .RESET_PC  (32'h0000_0000),
    .CTRL_W    (CTRL_W),
    .NOP_INSTR (32'h0000_0013),
    .CNT_W     (CNT_W)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .clk_gate               (clk_gate),
    .control_signals_select (control_signals_select),
    .branch_taken           (branch_taken),
    .branch_target          (branch_target),
    .imem_instr             (imem_instr),
    .id_ctrl                (id_ctrl),
    .id_rs1                 (id_rs1),
    .id_rs2                 (id_rs2),
    .id_rd                  (id_rd),
    .pc                     (pc),
    .if_id_pc               (if_id_pc),
    .if_id_instr            (if_id_instr),
    .if_id_valid            (if_id_valid),
    .id_ex_ctrl             (id_ex_ctrl),
    .id_ex_rs1              (id_ex_rs1),
    .id_ex_rs2              (id_ex_rs2),
    .id_ex_rd               (id_ex_rd),
    .id_ex_memRead          (id_ex_memRead),
    .stall_count            (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  function automatic exp_t ex(input logic [4:0] mask, input logic [31:0] epc,
                              input logic [31:0] eifpc, input logic [31:0] einstr,
                              input logic evalid, input logic [7:0] ectrl,
                              input logic [4:0] erd, input logic [4:0] ers1,
                              input logic [4:0] ers2, input logic [15:0] ecnt);
    exp_t e;
    e.mask = mask; e.pc = epc; e.ifpc = eifpc; e.instr = einstr; e.valid = evalid;
    e.ctrl = ectrl; e.rd = erd; e.rs1 = ers1; e.rs2 = ers2; e.cnt = ecnt;
    return e;
  endfunction

  // Monitor: one expectation per clock edge, sampled 1 unit after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.mask[0]) chk("pc", pc, e.pc);
      if (e.mask[1]) begin
        chk("if_id_pc", if_id_pc, e.ifpc);
        chk("if_id_instr", if_id_instr, e.instr);
        chk("if_id_valid", 32'(if_id_valid), 32'(e.valid));
      end
      if (e.mask[2]) begin
        chk("id_ex_ctrl", 32'(id_ex_ctrl), 32'(e.ctrl));
        chk("id_ex_rd", 32'(id_ex_rd), 32'(e.rd));
        chk("id_ex_memRead", 32'(id_ex_memRead), 32'(e.ctrl[1]));
      end
      if (e.mask[3]) begin
        chk("id_ex_rs1", 32'(id_ex_rs1), 32'(e.rs1));
        chk("id_ex_rs2", 32'(id_ex_rs2), 32'(e.rs2));
      end
      if (e.mask[4]) chk("stall_count", 32'(stall_count), 32'(e.cnt));
    end
  end

  // Drive one cycle of inputs (called just after a falling edge) and queue
  // the expected state after the following rising edge.
  task automatic step(input logic r, input logic g, input logic s, input logic b,
                      input logic [31:0] tgt, input logic [31:0] imem, input exp_t e);
    rst = r; clk_gate = g; control_signals_select = s; branch_taken = b;
    branch_target = tgt; imem_instr = imem;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] I0;
    logic [31:0] I1;
    logic [31:0] NOP;
    I0  = 32'h00A0_0093;
    I1  = 32'h0010_0113;
    NOP = 32'h0000_0013;
    rst = 1'b1; clk_gate = 1'b1; control_signals_select = 1'b1; branch_taken = 1'b0;
    branch_target = 32'h0; imem_instr = I0;
    id_ctrl = 8'h03; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd5;
    @(negedge clk);

    // reset
    step(1, 1, 1, 0, 0, I0, ex(M_ALL, 32'h0, 32'h0, NOP, 0, 8'h00, 0, 0, 0, 16'd0));
    step(1, 1, 1, 0, 0, I0, ex(M_ALL, 32'h0, 32'h0, NOP, 0, 8'h00, 0, 0, 0, 16'd0));
    // normal advance; first ID/EX load sees invalid IF/ID so ctrl is masked
    step(0, 1, 1, 0, 0, I0, ex(M_ALL, 32'h4, 32'h0, I0, 1, 8'h00, 5, 1, 2, 16'd0));
    step(0, 1, 1, 0, 0, I0, ex(M_ALL, 32'h8, 32'h4, I0, 1, 8'h03, 5, 1, 2, 16'd0));
    // load-use stall at pc=8: hold + bubble
    step(0, 0, 0, 0, 0, 32'hDEAD_BEEF, ex(M_ALL, 32'h8, 32'h4, I0, 1, 8'h00, 0, 1, 2, 16'd1));
    step(0, 1, 1, 0, 0, I1, ex(M_ALL, 32'hC, 32'h8, I1, 1, 8'h03, 5, 1, 2, 16'd1));
    step(0, 1, 1, 0, 0, I1, ex(M_ALL, 32'h10, 32'hC, I1, 1, 8'h03, 5, 1, 2, 16'd1));
    // mismatched pair: hold without bubble, then bubble without hold
    id_ctrl = 8'h01; id_rd = 5'd7;
    step(0, 0, 1, 0, 0, I0, ex(M_ALL, 32'h10, 32'hC, I1, 1, 8'h01, 7, 1, 2, 16'd2));
    id_ctrl = 8'h03; id_rd = 5'd5;
    step(0, 1, 0, 0, 0, I0, ex(M_ALL, 32'h14, 32'h10, I0, 1, 8'h00, 0, 1, 2, 16'd2));
    // branch with clk_gate=0: redirect overrides hold, no count
    step(0, 0, 1, 1, 32'h100, I0, ex(M_ALL, 32'h100, 32'h0, NOP, 0, 8'h00, 0, 1, 2, 16'd2));
    step(0, 1, 1, 0, 0, I0, ex(M_ALL, 32'h104, 32'h100, I0, 1, 8'h00, 5, 1, 2, 16'd2));
    step(0, 1, 1, 0, 0, I0, ex(M_ALL, 32'h108, 32'h104, I0, 1, 8'h03, 5, 1, 2, 16'd2));
    // reset during a 3-cycle stall
    step(0, 0, 0, 0, 0, I1, ex(M_ALL, 32'h108, 32'h104, I0, 1, 8'h00, 0, 1, 2, 16'd3));
    step(0, 0, 0, 0, 0, I1, ex(M_ALL, 32'h108, 32'h104, I0, 1, 8'h00, 0, 1, 2, 16'd4));
    step(1, 0, 0, 0, 0, I1, ex(M_ALL, 32'h0, 32'h0, NOP, 0, 8'h00, 0, 0, 0, 16'd0));
    // first fetch after reset is at RESET_PC
    step(0, 1, 1, 0, 0, I1, ex(M_ALL, 32'h4, 32'h0, I1, 1, 8'h00, 5, 1, 2, 16'd0));
    // pc wrap
    step(0, 1, 1, 1, 32'hFFFF_FFFC, I0,
         ex(M_PC | M_IF | M_CNT, 32'hFFFF_FFFC, 32'h0, NOP, 0, 8'h00, 0, 0, 0, 16'd0));
    step(0, 1, 1, 0, 0, I0,
         ex(M_PC | M_IF | M_CNT, 32'h0, 32'hFFFF_FFFC, I0, 1, 8'h00, 0, 0, 0, 16'd0));
    // long stall: counter saturates at all-ones
    for (int i = 0; i < 65600; i++) begin
      logic [4:0]  m;
      logic [15:0] c;
      m = 5'b0;
      c = 16'hFFFF;
      if (i == 0)     begin m = M_PC | M_CNT; c = 16'd1;     end
      if (i == 65533) begin m = M_CNT;        c = 16'hFFFE;  end
      if (i == 65534) begin m = M_CNT;        c = 16'hFFFF;  end
      if (i == 65599) begin m = M_PC | M_CNT; c = 16'hFFFF;  end
      step(0, 0, 0, 0, 0, I1, ex(m, 32'h0, 32'h0, NOP, 0, 8'h00, 0, 0, 0, c));
    end
    step(0, 0, 1, 1, 32'h200, I0, ex(M_PC | M_CNT, 32'h200, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF));
    step(1, 1, 1, 0, 0, I0, ex(M_ALL, 32'h0, 32'h0, NOP, 0, 8'h00, 0, 0, 0, 16'd0));

    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_regs.md
# pipeline_stall_regs

- Pipeline front-end register block that acts on the load-use stall request from the hazard detection unit.
- Holds the PC and IF/ID registers when a stall is requested, and inserts a bubble into the ID/EX control field.
- Redirects the PC and flushes younger stages on a taken branch.
- Exports the ID/EX `rd` and `memRead` that the hazard detection unit compares against.
- Sits between instruction fetch, decode and the EX stage.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CTRL_W, 8, width of decoded control bundle; bit 1 = memRead, bit 0 = regWrite
- NOP_INSTR, 32'h0000_0013, instruction word injected into IF/ID on flush/reset
- CNT_W, 16, width of stall statistics counter

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- clk_gate  in  1  1 = advance PC and IF/ID, 0 = hold (stall)
- control_signals_select  in  1  1 = pass decoded control, 0 = insert bubble into ID/EX
- branch_taken  in  1  resolved taken branch in EX
- branch_target  in  32  redirect address
- imem_instr  in  32  instruction fetched at `pc`
- id_ctrl  in  CTRL_W  decoded control for IF/ID instruction
- id_rs1, id_rs2, id_rd  in  5 each  decoded register fields
- pc  out  32  current fetch address
- if_id_pc, if_id_instr  out  32 each  IF/ID register
- if_id_valid  out  1  IF/ID holds a real instruction
- id_ex_ctrl  out  CTRL_W  ID/EX control
- id_ex_rs1, id_ex_rs2, id_ex_rd  out  5 each  ID/EX register fields
- id_ex_memRead  out  1  equals id_ex_ctrl[1]
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- Per-edge priority is rst > branch_taken > stall/bubble > normal advance.
- rst: pc=RESET_PC; if_id_pc=0; if_id_instr=NOP_INSTR; if_id_valid=0; all id_ex_* = 0; stall_count=0.
- branch_taken=1:
  - pc<=branch_target.
  - IF/ID<=NOP_INSTR with valid=0.
  - id_ex_ctrl<=0 and id_ex_rd<=0.
  - Overrides clk_gate and control_signals_select. The stall counter does not increment.
- Hold (clk_gate=0): pc, if_id_pc, if_id_instr and if_id_valid keep their values.
- Bubble (control_signals_select=0):
  - id_ex_ctrl<=0 and id_ex_rd<=0.
  - id_ex_rs1 and id_ex_rs2 still load the decoded fields; they are harmless.
- The hold and bubble controls act independently. The legal stall is both = 0. A mismatched pair is honoured bit-by-bit and is not flagged.
- Normal advance:
  - pc<=pc+4.
  - IF/ID<={pc, imem_instr} with valid=1.
  - ID/EX<={id_ctrl, id_rs1, id_rs2, id_rd}. id_ctrl is ANDed with if_id_valid, so an invalid IF/ID yields ctrl=0.
- stall_count increments by 1 on each non-reset, non-flush edge where clk_gate=0. It saturates at all-ones.
- Arithmetic: pc+4 wraps modulo 2^32 with no fault.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- id_ex_memRead is a wire of the register bit.
- A stall request sampled at edge N:
  - PC and IF/ID equal their pre-N values after N.
  - The bubble is visible in ID/EX after N.
  - The hazard unit sees id_ex_memRead=0 in cycle N+1, so a single load-use stall releases after exactly 1 cycle.
- A flush at edge N means fetch from branch_target in cycle N+1. The first valid IF/ID appears after N+1.
- Reset asserted mid-stall or mid-flush forces all reset values at the next edge.
- The first fetch after reset is at RESET_PC, in the cycle after rst falls.

## Structure
- Shared pipeline package holds:
  - the CTRL_W bit-index constants (CTRL_MEMREAD=1, CTRL_REGWRITE=0)
  - NOP_INSTR
  - RESET_PC
- One natural sub-module, `pipe_reg_en_clr`: a width-parameterised register with synchronous clear (priority) and enable, holding a clear value parameter. It is instanced for PC (clear value RESET_PC), IF/ID and ID/EX.
- The stall counter is inline.

## Test plan
- Reset, then 4 normal cycles with imem_instr=0x00A00093 → pc 0x0,0x4,0x8,0xC,0x10; if_id_valid=1 from the second edge; stall_count=0.
- Single load-use stall (clk_gate=0, select=0 for 1 cycle) with pc=0x8 → pc stays 0x8 for 1 extra cycle; IF/ID unchanged; id_ex_ctrl=0, id_ex_rd=0, id_ex_memRead=0; stall_count=1.
- branch_taken=1, target 0x100, asserted together with clk_gate=0 → pc=0x100, if_id_instr=0x00000013, if_id_valid=0, id_ex_ctrl=0, stall_count unchanged.
- rst asserted during a 3-cycle stall → all outputs at reset values next edge; stall_count=0.
- Stall held 70000 cycles with CNT_W=16 → stall_count saturates at 0xFFFF.
- pc=0xFFFFFFFC with normal advance → pc=0x00000000.
